rf_wr_arbiter: RTL
==================

# rf_wr_arbiter

Two-requester arbiter that shares the single register-file write port between the ALU writeback path (requester 0) and the load/return writeback path (requester 1). Requests use a valid/ready handshake. The winning write is registered and presented to the register file's enable-gated storage one cycle after acceptance. A sticky error flag reports handshake violations.

## Interface
Parameters:
- DATA_WIDTH, 16, write data width
- ADDR_WIDTH, 3, register index width (8 registers)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- hold  in  1  pipeline stall; while high, no request is accepted
- req0_valid  in  1  requester 0 has a write pending
- req0_addr  in  ADDR_WIDTH  requester 0 destination register
- req0_data  in  DATA_WIDTH  requester 0 write data
- req0_ready  out  1  requester 0 accepted this cycle (combinational)
- req1_valid, req1_addr, req1_data, req1_ready  same roles as requester 0, for requester 1
- wr_en  out  1  register-file write enable (registered)
- wr_addr  out  ADDR_WIDTH  register-file write index (registered)
- wr_data  out  DATA_WIDTH  register-file write data (registered)
- err  out  1  sticky handshake-violation flag (registered)

## Operation
- Transfer on requester i: reqi_valid && reqi_ready in the same cycle.
- Grant rule (RR, default):
  - hold=1 or rst=1 -> both ready=0.
  - Exactly one valid -> that requester is granted.
  - Both valid -> the requester not equal to `last` is granted.
  - At most one ready is high per cycle. The readys never depend on each other.
- `last` (1 bit) records the most recent granted requester and updates only on a transfer.
- Accepted addr/data are latched into wr_addr/wr_data with wr_en=1 on the next edge.
  - With no transfer, wr_en=0 on the next edge. wr_addr/wr_data hold their previous values.
- Same-address requests in one cycle are not merged. They are written in grant order across two consecutive cycles, and the later write wins.
- Handshake rule: once reqi_valid is high and not accepted, reqi_valid, reqi_addr and reqi_data must stay stable until the transfer.
  - Any violation sets err=1 on the next edge.
  - err stays high until rst.
- Each requester keeps a 1-bit "stalled" register plus a copy of its last addr/data for this check.

## Timing
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, err=0
  - last=1, so requester 0 is preferred first
  - stalled flags=0
- Acceptance-to-write latency: exactly 1 cycle. Throughput: 1 write/cycle sustained.
- hold asserted in cycle N -> no transfer in N; wr_en=0 in N+1.
- Continuous contention -> grants strictly alternate 0,1,0,1…
- Reset asserted mid-operation:
  - Outputs clear immediately (asynchronous); readys drop to 0.
  - A write registered but not yet consumed is dropped.
- Reset release: first grant possible in the first cycle after rst deasserts.
- A requester withdrawing valid while hold=1 counts as a violation (err=1).

## Configuration
- RF_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both are valid.
  - `last` is not implemented.
  - Requester 1 can starve. Intended for debug and single-issue bring-up.
- Not defined: round-robin behaviour as in Operation.

## Test plan
- Reset then idle: rst pulse mid-cycle -> wr_en=0, wr_addr=0, wr_data=0, err=0 asynchronously. No ready while rst=1.
- Single request: req0 valid, addr=3, data=16'hBEEF, cycle N -> req0_ready=1 in N. In N+1: wr_en=1, wr_addr=3, wr_data=16'hBEEF. In N+2: wr_en=0.
- Contention: both valid for 4 cycles after reset, req0 (addr=1, data=16'h0001), req1 (addr=2, data=16'h0002), new data each accept -> grants 0,1,0,1. wr_addr sequence 1,2,1,2 one cycle later. err=0.
- hold: both valid, hold=1 for 3 cycles -> no ready, wr_en=0. Release hold -> req0 granted first, then req1.
- Protocol violation: req1 valid, addr=5, data=16'h1234, blocked by hold; data changes to 16'h4321 -> err=1 next edge. err stays 1 after hold drops until rst.
- RF_ARB_FIXED_PRIO_EN build: both valid for 3 cycles -> req0 granted all 3. req1_ready=0 throughout.

Source files
------------

// File: rtl/rf_wr_arbiter_if.sv
// rf_wr_arbiter_if: request and write-port bundle for the register-file write
// arbiter. The slave modport is the arbiter's view; the master modport is the
// view of whatever drives the two requesters and observes the write port.
interface rf_wr_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);

  // Pipeline stall: while high, nothing is accepted.
  logic                  hold;

  // Requester 0: ALU writeback path.
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;

  // Requester 1: load/return writeback path.
  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;

  // Registered register-file write port and sticky protocol error flag.
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  err;

  modport slave (
    input  hold,
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output wr_en, wr_addr, wr_data, err
  );

  modport master (
    output hold,
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  wr_en, wr_addr, wr_data, err
  );

endinterface

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the single register-file write port between the ALU
// writeback path (requester 0) and the load/return path (requester 1).
//
// - Round-robin between the two requesters by default; the winning write is
//   registered and presented on wr_en/wr_addr/wr_data one cycle later.
// - A sticky err flag records any requester that changes or withdraws a
//   pending (valid but not yet accepted) request.
// - Define RF_ARB_FIXED_PRIO_EN for a fixed-priority build in which
//   requester 0 always wins and no round-robin pointer exists.
module rf_wr_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input logic           clk,
  input logic           rst,
  rf_wr_arbiter_if.slave bus
);

  // Snapshot of a requester's inputs from the previous cycle, used to detect
  // a pending request that changes before it is accepted.
  typedef struct packed {
    logic                  stalled;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } watch_t;

  logic                  grant0;
  logic                  grant1;
  logic                  xfer0;
  logic                  xfer1;
  logic                  viol0;
  logic                  viol1;
  watch_t                watch0;
  watch_t                watch1;

  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  err_q;

`ifdef RF_ARB_FIXED_PRIO_EN

  // Fixed priority: requester 0 wins whenever it is valid.
  always_comb begin
    grant0 = bus.req0_valid;
    grant1 = bus.req1_valid && !bus.req0_valid;
  end

`else

  // Most recently granted requester (0 or 1); reset to 1 so requester 0 is
  // preferred on the first contended cycle.
  logic last;

  // Round-robin: a lone requester always wins; under contention the one
  // that did not win last time gets the port.
  always_comb begin
    // NOTE: every always_comb output is assigned on every path (here
    // unconditionally); a missed path would infer a latch.
    grant0 = bus.req0_valid && (!bus.req1_valid ||  last);
    grant1 = bus.req1_valid && (!bus.req0_valid || !last);
  end

  // Remember the winner of the most recent transfer only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (xfer0) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of block order.
      last <= 1'b0;
    end else if (xfer1) begin
      last <= 1'b1;
    end
  end

`endif

  // Readys are masked by stall and by reset so nothing is accepted while
  // either is active. Each ready depends only on the valids, never on the
  // other ready.
  assign bus.req0_ready = grant0 && !bus.hold && !rst;
  assign bus.req1_ready = grant1 && !bus.hold && !rst;

  // A ready is only raised for a valid requester, so ready alone marks a
  // transfer.
  assign xfer0 = bus.req0_ready;
  assign xfer1 = bus.req1_ready;

  // Flag a requester that was stalled last cycle but now dropped valid or
  // changed its address or data.
  always_comb begin
    viol0 = watch0.stalled &&
            (!bus.req0_valid ||
             (bus.req0_addr != watch0.addr) ||
             (bus.req0_data != watch0.data));
    viol1 = watch1.stalled &&
            (!bus.req1_valid ||
             (bus.req1_addr != watch1.addr) ||
             (bus.req1_data != watch1.data));
  end

  // Capture each requester's stall state and inputs for next cycle's check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      watch0 <= '0;
      watch1 <= '0;
    end else begin
      watch0.stalled <= bus.req0_valid && !bus.req0_ready;
      watch0.addr    <= bus.req0_addr;
      watch0.data    <= bus.req0_data;
      watch1.stalled <= bus.req1_valid && !bus.req1_ready;
      watch1.addr    <= bus.req1_addr;
      watch1.data    <= bus.req1_data;
    end
  end

  // Register the accepted write; with no transfer the enable drops while
  // the last address and data are held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (xfer0) begin
      wr_en_q   <= 1'b1;
      wr_addr_q <= bus.req0_addr;
      wr_data_q <= bus.req0_data;
    end else if (xfer1) begin
      wr_en_q   <= 1'b1;
      wr_addr_q <= bus.req1_addr;
      wr_data_q <= bus.req1_data;
    end else begin
      wr_en_q   <= 1'b0;
    end
  end

  // Sticky handshake-violation flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (viol0 || viol1) begin
      err_q <= 1'b1;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.err     = err_q;

endmodule
